// File: rtl/rggen_rtl_pkg.sv
// Shared types and helpers for the rggen register-bus initiator blocks.
package rggen_rtl_pkg;

    typedef enum logic [1:0] {
        STATE_IDLE,
        STATE_SETUP,
        STATE_ACCESS,
        STATE_RESPOND
    } rggen_apb_master_state_e;

    typedef enum logic [1:0] {
        STATUS_OKAY    = 2'd0,
        STATUS_SLVERR  = 2'd1,
        STATUS_TIMEOUT = 2'd2
    } rggen_status_e;

    // Number of byte-offset bits below a bus word.
    function automatic int word_lsb(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/rggen_timeout_counter.sv
// Access-phase wait counter; flags the cycle in which the LIMIT-th stalled cycle occurs.
module rggen_timeout_counter #(
    parameter int LIMIT = 255
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_reached
);
    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] count;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            count <= '0;
        end else if (i_enable && (count != W'(LIMIT))) begin
            count <= count + W'(1);
        end
    end

    // count holds the stalled cycles already seen, so this cycle is number count+1.
    assign o_reached = i_enable && (count == W'(LIMIT - 1));

endmodule

// File: rtl/rggen_apb_master.sv
// APB initiator: one command in, one SETUP/ACCESS transfer, one response out.
// Optional access-phase timeout enabled by defining RGGEN_APB_MASTER_TIMEOUT_EN.
module rggen_apb_master
    import rggen_rtl_pkg::*;
#(
    parameter int ADDRESS_WIDTH  = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_command_valid,
    output logic                      o_command_ready,
    input  logic                      i_command_write,
    input  logic [ADDRESS_WIDTH-1:0]  i_command_address,
    input  logic [DATA_WIDTH-1:0]     i_command_write_data,
    input  logic [DATA_WIDTH/8-1:0]   i_command_strobe,
    output logic                      o_response_valid,
    input  logic                      i_response_ready,
    output logic [DATA_WIDTH-1:0]     o_response_read_data,
    output logic [1:0]                o_response_status,
    output logic                      o_psel,
    output logic                      o_penable,
    output logic                      o_pwrite,
    output logic [ADDRESS_WIDTH-1:0]  o_paddr,
    output logic [DATA_WIDTH-1:0]     o_pwdata,
    output logic [DATA_WIDTH/8-1:0]   o_pstrb,
    input  logic                      i_pready,
    input  logic                      i_pslverr,
    input  logic [DATA_WIDTH-1:0]     i_prdata
);
    localparam int LSB = word_lsb(DATA_WIDTH);
    localparam logic [ADDRESS_WIDTH-1:0] ADDR_MASK =
        ~((ADDRESS_WIDTH'(1) << LSB) - ADDRESS_WIDTH'(1));

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    rggen_apb_master_state_e state;
    logic                    timeout;

`ifdef RGGEN_APB_MASTER_TIMEOUT_EN
    rggen_timeout_counter #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout_counter (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_clear   (state == STATE_SETUP),
        .i_enable  ((state == STATE_ACCESS) && !i_pready),
        .o_reached (timeout)
    );
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state                <= STATE_IDLE;
            o_command_ready      <= 1'b0;
            o_response_valid     <= 1'b0;
            o_response_read_data <= '0;
            o_response_status    <= '0;
            o_psel               <= 1'b0;
            o_penable            <= 1'b0;
            o_pwrite             <= 1'b0;
            o_paddr              <= '0;
            o_pwdata             <= '0;
            o_pstrb              <= '0;
        end else begin
            case (state)
                STATE_IDLE: begin
                    o_command_ready <= 1'b1;
                    if (i_command_valid && o_command_ready) begin
                        o_command_ready <= 1'b0;
                        o_psel          <= 1'b1;
                        o_pwrite        <= i_command_write;
                        o_paddr         <= i_command_address & ADDR_MASK;
                        o_pwdata        <= i_command_write_data;
                        o_pstrb         <= i_command_write ? i_command_strobe : '0;
                        state           <= STATE_SETUP;
                    end
                end
                STATE_SETUP: begin
                    o_penable <= 1'b1;
                    state     <= STATE_ACCESS;
                end
                STATE_ACCESS: begin
                    // pready wins over a timeout flagged in the same cycle
                    if (i_pready) begin
                        o_psel               <= 1'b0;
                        o_penable            <= 1'b0;
                        o_response_valid     <= 1'b1;
                        o_response_read_data <= o_pwrite ? '0 : i_prdata;
                        o_response_status    <= i_pslverr ? STATUS_SLVERR : STATUS_OKAY;
                        state                <= STATE_RESPOND;
                    end else if (timeout) begin
                        o_psel               <= 1'b0;
                        o_penable            <= 1'b0;
                        o_response_valid     <= 1'b1;
                        o_response_read_data <= '0;
                        o_response_status    <= STATUS_TIMEOUT;
                        state                <= STATE_RESPOND;
                    end
                end
                STATE_RESPOND: begin
                    if (i_response_ready) begin
                        o_response_valid     <= 1'b0;
                        o_response_read_data <= '0;
                        o_response_status    <= '0;
                        o_command_ready      <= 1'b1;
                        state                <= STATE_IDLE;
                    end
                end
                default: begin
                    state <= STATE_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rggen_apb_master.sv
// Directed self-checking bench for rggen_apb_master (timeout steps need RGGEN_APB_MASTER_TIMEOUT_EN).
module tb_rggen_apb_master;
    localparam int AW = 8;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          command_valid;
    logic          command_ready;
    logic          command_write;
    logic [AW-1:0] command_address;
    logic [DW-1:0] command_write_data;
    logic [3:0]    command_strobe;
    logic          response_valid;
    logic          response_ready;
    logic [DW-1:0] response_read_data;
    logic [1:0]    response_status;
    logic          psel, penable, pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [3:0]    pstrb;
    logic          pready, pslverr;
    logic [DW-1:0] prdata;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rggen_apb_master #(
        .ADDRESS_WIDTH  (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .i_clk                (clk),
        .i_rst                (rst),
        .i_command_valid      (command_valid),
        .o_command_ready      (command_ready),
        .i_command_write      (command_write),
        .i_command_address    (command_address),
        .i_command_write_data (command_write_data),
        .i_command_strobe     (command_strobe),
        .o_response_valid     (response_valid),
        .i_response_ready     (response_ready),
        .o_response_read_data (response_read_data),
        .o_response_status    (response_status),
        .o_psel               (psel),
        .o_penable            (penable),
        .o_pwrite             (pwrite),
        .o_paddr              (paddr),
        .o_pwdata             (pwdata),
        .o_pstrb              (pstrb),
        .i_pready             (pready),
        .i_pslverr            (pslverr),
        .i_prdata             (prdata)
    );

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [3:0] s);
        command_valid      = 1'b1;
        command_write      = wr;
        command_address    = a;
        command_write_data = d;
        command_strobe     = s;
    endtask

    task automatic handshake_response();
        response_ready = 1'b1;
        tick();
        response_ready = 1'b0;
        chk("resp_cleared", {63'd0, response_valid}, 64'd0);
        chk("ready_back", {63'd0, command_ready}, 64'd1);
    endtask

    initial begin
        rst = 1'b1;
        command_valid = 1'b0; command_write = 1'b0; command_address = '0;
        command_write_data = '0; command_strobe = '0; response_ready = 1'b0;
        pready = 1'b0; pslverr = 1'b0; prdata = '0;
        tick(); tick();
        chk("rst_cmd_ready", {63'd0, command_ready}, 64'd0);
        chk("rst_resp_valid", {63'd0, response_valid}, 64'd0);
        chk("rst_psel", {63'd0, psel}, 64'd0);
        chk("rst_paddr", {56'd0, paddr}, 64'd0);
        rst = 1'b0;
        tick();
        chk("idle_ready", {63'd0, command_ready}, 64'd1);

        // Write, zero wait states
        issue(1'b1, 8'h13, 32'hDEADBEEF, 4'hF);
        pready = 1'b1;
        tick();
        command_valid = 1'b0;
        chk("wr_setup_psel", {63'd0, psel}, 64'd1);
        chk("wr_setup_penable", {63'd0, penable}, 64'd0);
        chk("wr_paddr", {56'd0, paddr}, 64'h10);
        chk("wr_pwrite", {63'd0, pwrite}, 64'd1);
        chk("wr_pstrb", {60'd0, pstrb}, 64'hF);
        chk("wr_pwdata", {32'd0, pwdata}, 64'hDEADBEEF);
        chk("wr_setup_ready", {63'd0, command_ready}, 64'd0);
        tick();
        chk("wr_access_penable", {62'd0, psel, penable}, 64'd3);
        tick();
        chk("wr_resp_valid", {63'd0, response_valid}, 64'd1);
        chk("wr_status", {62'd0, response_status}, 64'd0);
        chk("wr_rdata_zero", {32'd0, response_read_data}, 64'd0);
        chk("wr_resp_psel", {62'd0, psel, penable}, 64'd0);
        handshake_response();

        // Read with three wait states
        pready = 1'b0;
        prdata = 32'hFFFF0000;
        issue(1'b0, 8'h26, 32'h0, 4'hF);
        tick();
        command_valid = 1'b0;
        chk("rd_pstrb_zero", {60'd0, pstrb}, 64'd0);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("rd_access_ctl", {62'd0, psel, penable}, 64'd3);
            chk("rd_access_paddr", {56'd0, paddr}, 64'h24);
            chk("rd_access_pwrite", {63'd0, pwrite}, 64'd0);
            chk("rd_no_resp", {63'd0, response_valid}, 64'd0);
            if (i == 3) begin
                pready = 1'b1;
                prdata = 32'h12345678;
            end
            tick();
        end
        pready = 1'b0;
        chk("rd_resp_valid", {63'd0, response_valid}, 64'd1);
        chk("rd_rdata", {32'd0, response_read_data}, 64'h12345678);
        chk("rd_status", {62'd0, response_status}, 64'd0);
        handshake_response();

        // Read with slave error; response held under backpressure
        pready = 1'b1; pslverr = 1'b1; prdata = 32'hAAAA5555;
        issue(1'b0, 8'h08, 32'h0, 4'h0);
        tick();
        command_valid = 1'b0;
        tick(); tick();
        pready = 1'b0; pslverr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("err_hold_valid", {63'd0, response_valid}, 64'd1);
            chk("err_hold_status", {62'd0, response_status}, 64'd1);
            chk("err_hold_rdata", {32'd0, response_read_data}, 64'hAAAA5555);
            chk("err_hold_ready", {63'd0, command_ready}, 64'd0);
            tick();
        end
        response_ready = 1'b1;
        tick();
        response_ready = 1'b0;
        chk("err_clr_valid", {63'd0, response_valid}, 64'd0);
        chk("err_clr_status", {62'd0, response_status}, 64'd0);
        chk("err_clr_rdata", {32'd0, response_read_data}, 64'd0);
        chk("err_ready_back", {63'd0, command_ready}, 64'd1);

        // Back-to-back writes with command_valid held high
        pready = 1'b1;
        issue(1'b1, 8'h40, 32'h1, 4'h3);
        tick();
        chk("b2b1_paddr", {56'd0, paddr}, 64'h40);
        chk("b2b1_pstrb", {60'd0, pstrb}, 64'h3);
        issue(1'b1, 8'h44, 32'h2, 4'hC);
        tick(); tick();
        chk("b2b1_resp", {63'd0, response_valid}, 64'd1);
        chk("b2b_wait_ready", {63'd0, command_ready}, 64'd0);
        response_ready = 1'b1;
        tick();
        response_ready = 1'b0;
        chk("b2b_idle_psel", {63'd0, psel}, 64'd0);
        chk("b2b_idle_ready", {63'd0, command_ready}, 64'd1);
        tick();
        command_valid = 1'b0;
        chk("b2b2_psel", {63'd0, psel}, 64'd1);
        chk("b2b2_paddr", {56'd0, paddr}, 64'h44);
        chk("b2b2_pwdata", {32'd0, pwdata}, 64'h2);
        chk("b2b2_pstrb", {60'd0, pstrb}, 64'hC);
        tick(); tick();
        chk("b2b2_resp", {63'd0, response_valid}, 64'd1);
        handshake_response();

`ifdef RGGEN_APB_MASTER_TIMEOUT_EN
        // Timeout after four stalled ACCESS cycles
        pready = 1'b0; prdata = 32'hCAFEF00D;
        issue(1'b0, 8'h10, 32'h0, 4'h0);
        tick();
        command_valid = 1'b0;
        tick(); tick(); tick(); tick();
        chk("to_a4_psel", {62'd0, psel, penable}, 64'd3);
        tick();
        chk("to_psel_drop", {62'd0, psel, penable}, 64'd0);
        chk("to_status", {62'd0, response_status}, 64'd2);
        chk("to_rdata", {32'd0, response_read_data}, 64'd0);
        handshake_response();

        // pready in the fourth ACCESS cycle wins over the timeout
        issue(1'b0, 8'h10, 32'h0, 4'h0);
        tick();
        command_valid = 1'b0;
        tick(); tick(); tick(); tick();
        pready = 1'b1;
        tick();
        pready = 1'b0;
        chk("to_win_status", {62'd0, response_status}, 64'd0);
        chk("to_win_rdata", {32'd0, response_read_data}, 64'hCAFEF00D);
        handshake_response();
`endif

        // Reset during ACCESS aborts the transfer
        pready = 1'b0;
        issue(1'b1, 8'h20, 32'h55, 4'hF);
        tick();
        command_valid = 1'b0;
        tick();
        chk("rstacc_in_access", {62'd0, psel, penable}, 64'd3);
        rst = 1'b1;
        pready = 1'b1;
        tick();
        chk("rstacc_psel", {63'd0, psel}, 64'd0);
        chk("rstacc_penable", {63'd0, penable}, 64'd0);
        chk("rstacc_resp", {63'd0, response_valid}, 64'd0);
        chk("rstacc_ready", {63'd0, command_ready}, 64'd0);
        rst = 1'b0;
        pready = 1'b0;
        tick();
        chk("rstacc_idle_ready", {63'd0, command_ready}, 64'd1);
        chk("rstacc_no_resp", {63'd0, response_valid}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
